// File: rtl/traffic_light.sv
// Fixed-time two-road traffic light controller (Moore FSM with a per-phase cycle timer).
// Define TRAFFIC_LIGHT_ALLRED_EN to insert an all-red clearance phase after each yellow.
module traffic_light #(
    parameter int GREEN_CYCLES  = 5,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] red_light,
    output logic [1:0] yellow_light,
    output logic [1:0] green_light
);

    localparam int MAX_GY    = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
    localparam int MAX_ALL   = (MAX_GY > ALLRED_CYCLES) ? MAX_GY : ALLRED_CYCLES;
    localparam int CNT_W     = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
`ifdef TRAFFIC_LIGHT_ALLRED_EN
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_G0  = 3'd0,
        ST_Y0  = 3'd1,
        ST_AR0 = 3'd2,
        ST_G1  = 3'd3,
        ST_Y1  = 3'd4,
        ST_AR1 = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_done;

    // NOTE: reset is in the sensitivity list so lamps fall back to G0 without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_G0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so state and counter both update from the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        phase_done = 1'b0;
        unique case (state_q)
            ST_G0: begin
                phase_done = (cnt_q == GREEN_LAST);
                if (phase_done) state_d = ST_Y0;
            end
            ST_Y0: begin
                phase_done = (cnt_q == YELLOW_LAST);
`ifdef TRAFFIC_LIGHT_ALLRED_EN
                if (phase_done) state_d = ST_AR0;
`else
                if (phase_done) state_d = ST_G1;
`endif
            end
            ST_G1: begin
                phase_done = (cnt_q == GREEN_LAST);
                if (phase_done) state_d = ST_Y1;
            end
            ST_Y1: begin
                phase_done = (cnt_q == YELLOW_LAST);
`ifdef TRAFFIC_LIGHT_ALLRED_EN
                if (phase_done) state_d = ST_AR1;
`else
                if (phase_done) state_d = ST_G0;
`endif
            end
`ifdef TRAFFIC_LIGHT_ALLRED_EN
            ST_AR0: begin
                phase_done = (cnt_q == ALLRED_LAST);
                if (phase_done) state_d = ST_G1;
            end
            ST_AR1: begin
                phase_done = (cnt_q == ALLRED_LAST);
                if (phase_done) state_d = ST_G0;
            end
`endif
            // Unused encodings (and AR states when clearance is disabled) recover to G0.
            default: begin
                phase_done = 1'b1;
                state_d    = ST_G0;
            end
        endcase
        cnt_d = phase_done ? '0 : cnt_q + 1'b1;
    end

    // Lamp decode; bit1 = road 1, bit0 = road 0. Defaults are the G0 pattern.
    always_comb begin
        red_light    = 2'b10;
        yellow_light = 2'b00;
        green_light  = 2'b01;
        case (state_q)
            ST_G0: ;
            ST_Y0: begin
                yellow_light = 2'b01;
                green_light  = 2'b00;
            end
            ST_G1: begin
                red_light   = 2'b01;
                green_light = 2'b10;
            end
            ST_Y1: begin
                red_light    = 2'b01;
                yellow_light = 2'b10;
                green_light  = 2'b00;
            end
`ifdef TRAFFIC_LIGHT_ALLRED_EN
            ST_AR0, ST_AR1: begin
                red_light   = 2'b11;
                green_light = 2'b00;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// Self-checking bench for traffic_light: vector table, reset corner cases, and a randomized
// run against a phase-list reference model. Adapts to TRAFFIC_LIGHT_ALLRED_EN.
module tb_traffic_light;

    localparam logic [5:0] V_G0 = 6'b10_00_01;  // {red, yellow, green}
    localparam logic [5:0] V_Y0 = 6'b10_01_00;
    localparam logic [5:0] V_AR = 6'b11_00_00;
    localparam logic [5:0] V_G1 = 6'b01_00_10;
    localparam logic [5:0] V_Y1 = 6'b01_10_00;

`ifdef TRAFFIC_LIGHT_ALLRED_EN
    localparam int G1_START = 9;
`else
    localparam int G1_START = 8;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] r, y, g;
    logic [1:0] fr, fy, fg;

    int tests = 0;
    int fails = 0;
    int n;  // rising edges since the last reset release

    initial clk = 1'b0;
    always #5 clk = ~clk;

    traffic_light dut (
        .clk(clk), .reset(reset),
        .red_light(r), .yellow_light(y), .green_light(g)
    );

    traffic_light #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1)) dut_fast (
        .clk(clk), .reset(reset),
        .red_light(fr), .yellow_light(fy), .green_light(fg)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    // Expected lamps after cnt edges: walk the list of (duration, pattern) phases.
    function automatic logic [5:0] model(int gl, int yl, int cnt);
        int         lens[$];
        logic [5:0] vals[$];
        int         period;
        int         p;
        lens.push_back(gl); vals.push_back(V_G0);
        lens.push_back(yl); vals.push_back(V_Y0);
`ifdef TRAFFIC_LIGHT_ALLRED_EN
        lens.push_back(1);  vals.push_back(V_AR);
`endif
        lens.push_back(gl); vals.push_back(V_G1);
        lens.push_back(yl); vals.push_back(V_Y1);
`ifdef TRAFFIC_LIGHT_ALLRED_EN
        lens.push_back(1);  vals.push_back(V_AR);
`endif
        period = 0;
        foreach (lens[i]) period += lens[i];
        p = cnt % period;
        foreach (lens[i]) begin
            if (p < lens[i]) return vals[i];
            p -= lens[i];
        end
        return V_G0;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got r=%b y=%b g=%b, want r=%b y=%b g=%b",
                     name, act[5:4], act[3:2], act[1:0], exp[5:4], exp[3:2], exp[1:0]);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check_invariants(input string tag, input logic [1:0] rr,
                                    input logic [1:0] yy, input logic [1:0] gg);
        for (int b = 0; b < 2; b++)
            check_bit($sformatf("%s_onehot%0d", tag, b),
                      (2'(rr[b]) + 2'(yy[b]) + 2'(gg[b])) == 2'd1, 1'b1);
        check_bit({tag, "_one_road_moving"}, rr != 2'b00, 1'b1);
`ifndef TRAFFIC_LIGHT_ALLRED_EN
        check_bit({tag, "_no_allred"}, rr != 2'b11, 1'b1);
`endif
    endtask

    typedef struct {
        logic       rst;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int hold;

        // Three reset cycles, then cycles 1..17 after release.
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, V_G0});
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, V_G0});
        for (int i = 0; i < 2; i++) tbl.push_back('{1'b0, V_Y0});
`ifdef TRAFFIC_LIGHT_ALLRED_EN
        tbl.push_back('{1'b0, V_AR});
`endif
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, V_G1});
        for (int i = 0; i < 2; i++) tbl.push_back('{1'b0, V_Y1});
`ifdef TRAFFIC_LIGHT_ALLRED_EN
        tbl.push_back('{1'b0, V_AR});
        tbl.push_back('{1'b0, V_G0});
`else
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, V_G0});
`endif

        reset = 1'b1;
        foreach (tbl[i]) begin
            @(negedge clk);
            reset = tbl[i].rst;
            #1;
            check($sformatf("vec%0d", i), {r, y, g}, tbl[i].exp);
            check($sformatf("fast_vec%0d", i), {fr, fy, fg}, model(1, 1, n));
        end

        // Reset asserted between clock edges takes effect immediately and holds.
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", {r, y, g}, V_G0);
        check("async_reset_fast", {fr, fy, fg}, V_G0);
        repeat (2) begin
            @(negedge clk);
            #1 check("reset_hold", {r, y, g}, V_G0);
        end

        // After release G0 lasts exactly GREEN_CYCLES, then yellow.
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1 check($sformatf("release_c%0d", c), {r, y, g}, (c <= 5) ? V_G0 : V_Y0);
            @(negedge clk);
        end
        for (int c = 7; c < G1_START + 2; c++) @(negedge clk);

        // Reset in the third cycle of G1, then a full G0 again.
        #1 check("g1_cycle3", {r, y, g}, V_G1);
        #2 reset = 1'b1;
        #1 check("midphase_reset", {r, y, g}, V_G0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1 check($sformatf("post_mid_c%0d", c), {r, y, g}, (c <= 5) ? V_G0 : V_Y0);
            @(negedge clk);
        end

        // Randomized run with occasional mid-cycle resets, both instances vs the model.
        hold = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            #1;
            check($sformatf("rand%0d", cyc), {r, y, g}, reset ? V_G0 : model(5, 2, n));
            check($sformatf("rand_fast%0d", cyc), {fr, fy, fg}, reset ? V_G0 : model(1, 1, n));
            check_invariants("inv", r, y, g);
            check_invariants("inv_fast", fr, fy, fg);
            if (reset) begin
                if (hold == 0) reset = 1'b0;
                else hold--;
            end else if ($urandom_range(0, 29) == 0) begin
                #($urandom_range(1, 2));
                reset = 1'b1;
                hold  = $urandom_range(0, 2);
                #1 check($sformatf("rand_async%0d", cyc), {r, y, g}, V_G0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
